alu_sched: RTL and testbench

//  Shares one combinational 16-bit alu (Aluctrl/din1/din2 -> dout) among NREQ requesters.

---
 rtl/alu_sched.sv | 166 ++++++++++++++++
 tb/tb_alu_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched
// Description : Shares one combinational 16-bit ALU among NREQ requesters.
//               Round-robin arbitration, operand latching, ALU sequencing
//               (IDLE -> SETUP -> EXEC -> RESP) and result return tagged with
//               the owning requester's index.
// Ports       : clk, rst (async, active high)
//               req_valid/req_op/req_a/req_b/req_ready : requester side
//               rsp_valid/rsp_id/rsp_data/rsp_ready    : result side
//               alu_ctrl/alu_din1/alu_din2/alu_dout    : to/from the ALU
// Options     : ALU_SCHED_MUL_WAIT_EN - when defined, mul (4'b0011) holds the
//               EXEC state for MUL_WAIT cycles; otherwise every op spends one
//               cycle in EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sched #(
   parameter int NREQ     = 2,
   parameter int IDW      = 1,
   parameter int MUL_WAIT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [4*NREQ-1:0]    req_op,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [15:0]          rsp_data,
   input  logic                 rsp_ready,
   output logic [3:0]           alu_ctrl,
   output logic [15:0]          alu_din1,
   output logic [15:0]          alu_din2,
   input  logic [15:0]          alu_dout
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_setup = 2'd1;
   localparam logic [1:0] c_st_exec  = 2'd2;
   localparam logic [1:0] c_st_resp  = 2'd3;

   localparam logic [3:0] c_op_pass  = 4'b0000;

   logic [1:0]       r_state;
   logic [IDW-1:0]   r_rr;
   logic [IDW-1:0]   r_id;
   logic [3:0]       r_op;
   logic [15:0]      r_din1;
   logic [15:0]      r_din2;
   logic [15:0]      r_data;

   logic [NREQ-1:0]  w_grant;
   logic             w_hit;
   logic [IDW-1:0]   w_gid;
   logic [IDW-1:0]   w_rr_next;
   logic [3:0]       w_op;
   logic [15:0]      w_a;
   logic [15:0]      w_b;
   logic             w_accept;
   logic             w_exec_last;
   int               w_idx;

   // Scan from the round-robin pointer upward with wrap; first valid wins.
   always_comb begin
      w_grant = '0;
      w_hit   = 1'b0;
      w_gid   = '0;
      w_op    = '0;
      w_a     = '0;
      w_b     = '0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (int'(r_rr) + k) % NREQ;
         if (!w_hit && req_valid[w_idx]) begin
            w_hit          = 1'b1;
            w_gid          = IDW'(w_idx);
            w_grant[w_idx] = 1'b1;
            w_op           = req_op[4*w_idx +: 4];
            w_a            = req_a[16*w_idx +: 16];
            w_b            = req_b[16*w_idx +: 16];
         end
      end
   end

   assign w_rr_next = (int'(w_gid) == NREQ - 1) ? '0 : w_gid + IDW'(1);

   // Grant is visible only in IDLE and never while reset is held.
   assign req_ready = (r_state == c_st_idle && !rst) ? w_grant : '0;
   assign w_accept  = |req_ready;

`ifdef ALU_SCHED_MUL_WAIT_EN
   localparam logic [3:0] c_op_mul = 4'b0011;
   localparam int         c_cw     = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;
   localparam logic [c_cw-1:0] c_cnt_load = c_cw'(MUL_WAIT - 1);

   logic [c_cw-1:0] r_cnt;

   // Remaining EXEC cycles after the current one; mul loads MUL_WAIT-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == c_st_setup) begin
         r_cnt <= (r_op == c_op_mul) ? c_cnt_load : '0;
      end else if (r_state == c_st_exec && r_cnt != '0) begin
         r_cnt <= r_cnt - c_cw'(1);
      end
   end

   assign w_exec_last = (r_cnt == '0);
`else
   // One EXEC cycle for every op; MUL_WAIT is at least 1 so this is high.
   assign w_exec_last = (MUL_WAIT >= 1);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_rr    <= '0;
         r_id    <= '0;
         r_op    <= '0;
         r_din1  <= '0;
         r_din2  <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_op    <= w_op;
                  r_din1  <= w_a;
                  r_din2  <= w_b;
                  r_id    <= w_gid;
                  r_rr    <= w_rr_next;
                  r_state <= c_st_setup;
               end
            end
            c_st_setup: begin
               r_state <= c_st_exec;
            end
            c_st_exec: begin
               if (w_exec_last) begin
                  // Pass-through op never drives the ALU; take A directly.
                  r_data  <= (r_op == c_op_pass) ? r_din1 : alu_dout;
                  r_state <= c_st_resp;
               end
            end
            default: begin
               if (rsp_ready) begin
                  r_state <= c_st_idle;
               end
            end
         endcase
      end
   end

   // Ctrl returns to 0 outside EXEC so the ALU sees a transition per op.
   assign alu_ctrl  = (r_state == c_st_exec) ? r_op : 4'b0000;
   assign alu_din1  = r_din1;
   assign alu_din2  = r_din2;
   assign rsp_valid = (r_state == c_st_resp);
   assign rsp_id    = r_id;
   assign rsp_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sched
// Description : Self-checking bench for alu_sched. A behavioural ALU drives
//               alu_dout; a transaction-level model (arbitration order,
//               latency, expected result) checks every output every cycle
//               under directed and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sched;

   localparam int NREQ     = 3;
   localparam int IDW      = 2;
   localparam int MUL_WAIT = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [4*NREQ-1:0]    req_op    = '0;
   logic [16*NREQ-1:0]   req_a     = '0;
   logic [16*NREQ-1:0]   req_b     = '0;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [15:0]          rsp_data;
   logic                 rsp_ready = 1'b1;
   logic [3:0]           alu_ctrl;
   logic [15:0]          alu_din1;
   logic [15:0]          alu_din2;
   logic [15:0]          alu_dout;

   alu_sched #(.NREQ(NREQ), .IDW(IDW), .MUL_WAIT(MUL_WAIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .alu_ctrl  (alu_ctrl),
      .alu_din1  (alu_din1),
      .alu_din2  (alu_din2),
      .alu_dout  (alu_dout)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: unknown ctrl codes (and 0) return din1.
   function automatic logic [15:0] alu_fn(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a * b;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         4'd7:    return a << b[3:0];
         default: return a;
      endcase
   endfunction

   always_comb alu_dout = alu_fn(alu_ctrl, alu_din1, alu_din2);

   // Expected scheduler result: op 0 returns A without using the ALU.
   function automatic logic [15:0] ref_result(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
      return (op == 4'd0) ? a : alu_fn(op, a, b);
   endfunction

   function automatic int op_latency(input logic [3:0] op);
`ifdef ALU_SCHED_MUL_WAIT_EN
      if (op == 4'd3) return 2 + MUL_WAIT;
`endif
      return 3;
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Requester model
   bit          pend [NREQ];
   logic [3:0]  pop  [NREQ];
   logic [15:0] pa   [NREQ];
   logic [15:0] pb   [NREQ];
   int          renew    = 0;   // 0 none, 1 re-request same op, 2 random
   int          rdy_mode = 1;   // 0 low, 1 high, 2 random
   bit          rst_now  = 1'b0;

   // Transaction model
   int          cyc  = 0;
   bit          busy = 1'b0;
   int          acc  = 0;
   int          due  = 0;
   int          rr   = 0;
   int          cid  = 0;
   logic [3:0]  c_op = '0;
   logic [15:0] ca   = '0;
   logic [15:0] cb   = '0;
   logic [15:0] cdat = '0;

   task automatic set_req(input int i, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b);
      pend[i] = 1'b1; pop[i] = op; pa[i] = a; pb[i] = b;
   endtask

   task automatic step();
      logic [NREQ-1:0] exp_ready;
      logic [3:0]      exp_ctrl;
      bit              exp_rv;
      int              gid;
      @(posedge clk);
      #1;
      cyc++;
      if (renew == 2) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0)
               set_req(i, ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15)),
                       16'($urandom), 16'($urandom));
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = pend[i];
         req_op[4*i +: 4]     = pop[i];
         req_a[16*i +: 16]    = pa[i];
         req_b[16*i +: 16]    = pb[i];
      end
      rsp_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
      if (rst_now) rst = 1'b1;
      #1;
      if (rst) begin
         check("rst_ready", 32'(req_ready), 32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_rsp_id", 32'(rsp_id), 32'd0);
         check("rst_rsp_data", 32'(rsp_data), 32'd0);
         check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
         check("rst_alu_din1", 32'(alu_din1), 32'd0);
         check("rst_alu_din2", 32'(alu_din2), 32'd0);
         busy = 1'b0;
         rr   = 0;
         return;
      end
      exp_ready = '0;
      gid = -1;
      if (!busy) begin
         for (int k = 0; k < NREQ; k++) begin
            if (gid < 0 && pend[(rr + k) % NREQ]) gid = (rr + k) % NREQ;
         end
         if (gid >= 0) exp_ready[gid] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      exp_rv = busy && (cyc >= due);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         check("rsp_id", 32'(rsp_id), 32'(cid));
         check("rsp_data", 32'(rsp_data), 32'(cdat));
      end
      exp_ctrl = (busy && cyc >= acc + 2 && cyc < due) ? c_op : 4'd0;
      check("alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl));
      if (busy && cyc >= acc + 1 && cyc < due) begin
         check("alu_din1", 32'(alu_din1), 32'(ca));
         check("alu_din2", 32'(alu_din2), 32'(cb));
      end
      if (exp_rv && rsp_ready) begin
         busy = 1'b0;
      end else if (gid >= 0) begin
         busy = 1'b1;
         acc  = cyc;
         due  = cyc + op_latency(pop[gid]);
         cid  = gid;
         c_op = pop[gid];
         ca   = pa[gid];
         cb   = pb[gid];
         cdat = ref_result(pop[gid], pa[gid], pb[gid]);
         rr   = (gid + 1) % NREQ;
         pend[gid] = (renew == 1);
      end
   endtask

   task automatic run_idle(input int bound);
      bit any;
      for (int n = 0; n < bound; n++) begin
         any = busy;
         for (int i = 0; i < NREQ; i++) any |= pend[i];
         if (!any) break;
         step();
      end
      any = busy;
      for (int i = 0; i < NREQ; i++) any |= pend[i];
      check("idle_timeout", 32'(any), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0;
      end
      // Reset state
      step();
      step();
      rst = 1'b0;
      step();

      // Single add on requester 0
      set_req(0, 4'd1, 16'h0003, 16'h0004);
      run_idle(30);

      // Two requesters held valid: grants alternate 0,1,0,1
      renew = 1;
      set_req(0, 4'd2, 16'h0010, 16'h0001);
      set_req(1, 4'd2, 16'h0010, 16'h0001);
      repeat (17) step();
      renew = 0;
      run_idle(40);

      // Mul truncation and latency
      set_req(1, 4'd3, 16'h0100, 16'h0100);
      run_idle(30);

      // Consumer stalls for 10 cycles with a second request waiting
      rdy_mode = 0;
      set_req(2, 4'd1, 16'h1234, 16'h1111);
      set_req(0, 4'd6, 16'h00FF, 16'h0F0F);
      repeat (15) step();
      rdy_mode = 1;
      run_idle(40);

      // Reset during EXEC drops the op
      set_req(1, 4'd2, 16'h5555, 16'h1111);
      for (int n = 0; n < 20 && !(busy && cyc == acc + 1); n++) step();
      check("reach_exec", 32'(busy && cyc == acc + 1), 32'd1);
      rst_now = 1'b1;
      step();
      step();
      rst_now = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      repeat (8) step();

      // Pass-through op keeps alu_ctrl at 0
      set_req(2, 4'd0, 16'hBEEF, 16'h1234);
      run_idle(30);

      // Randomized traffic with random back-pressure
      renew = 2;
      rdy_mode = 2;
      repeat (800) step();
      renew = 0;
      rdy_mode = 1;
      run_idle(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
